rr_moore_arbiter: RTL
=====================

Name: rr_moore_arbiter

Overview:
Four-requester round-robin arbiter built as a Moore state machine. It shares one downstream resource, such as an FSM-driven datapath, between four requesters. Grants are registered and depend only on state, with a bounded tenure per grant. A state_num debug output exposes the FSM state for benches and waveforms.

Parameters:
MAX_HOLD, 8, maximum grant tenure in cycles before preemption when another requester is waiting; legal range 1..15
CNT_W, 4, width of the tenure counter; must satisfy 2**CNT_W > MAX_HOLD

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request per requester; held high for the whole use of the resource, dropped to release
gnt  output 4  one-hot grant, registered; all-zero when no grant is active
gnt_id  output 2  index of the current or last owner; valid when busy=1
busy  output 1  high while in GRANT
state_num  output 2  debug code: IDLE=0, GRANT=1, GAP=2

Behaviour:
- Interface: one clock, clk; reset, rst, is synchronous and active-high.
- Reset: takes effect on the next rising edge while rst=1, including mid-grant.
  - state=IDLE, gnt=0, gnt_id=0, busy=0, state_num=0, hold_cnt=0.
  - Rotation pointer last=3, so req[0] has highest priority first.
- Moore outputs: gnt, gnt_id, busy and state_num are decoded from registered state and owner only. No combinational path from req to any output.
- Pick function: search from (base+1) mod 4 upward with wrap; the first set req bit wins.
- IDLE:
  - If req != 0: pick with base=last. Next state GRANT, owner<=winner, hold_cnt<=1.
  - Grant latency is one cycle from req sampled high to gnt high.
  - If req == 0: stay in IDLE.
- GRANT: gnt[owner]=1, busy=1.
  - If req[owner]=0: next state GAP (voluntary release).
  - Else if hold_cnt==MAX_HOLD and (req & ~onehot(owner)) != 0: next state GAP (preemption).
  - Else stay in GRANT. hold_cnt increments, saturating at MAX_HOLD, so a lone requester keeps the grant indefinitely.
- GAP: exactly one cycle with gnt=0 (turnaround), last<=owner.
  - If req != 0: pick with base=owner. Next state GRANT, owner<=winner, hold_cnt<=1.
  - Else: next state IDLE.
  - The previous owner has lowest priority. It can be re-granted only if it is the sole requester.
- Simultaneous events: release and preemption in the same cycle are both handled as GAP, identically. A requester raising req during GAP is considered in that cycle's pick.
- Illegal state code 3: next state IDLE, gnt=0.
- Invariants: at most one gnt bit high; gnt=0 in IDLE and GAP; gnt_id holds its value in IDLE and GAP.

Decomposition:
- Shared package arb_pkg:
  - state localparams S_IDLE=2'd0, S_GRANT=2'd1, S_GAP=2'd2
  - N_REQ=4
  - onehot helper function
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req[3:0], base[1:0].
  - Outputs: valid, idx[1:0].
  - Instantiated once and fed base=last in IDLE, base=owner in GAP.
- Top holds the state register, owner, last, hold_cnt and the output decode.

Test Plan:
1. Reset, then req=4'b0001 held for 5 cycles, then dropped -> gnt=0001 from cycle 1 after req, busy=1, state_num=1; GAP (state_num=2, gnt=0) for one cycle after drop, then IDLE (state_num=0).
2. From reset, req=4'b1111 held constantly, MAX_HOLD=8 -> grants 0,1,2,3,0 in order; each gnt high exactly 8 cycles, separated by one GAP cycle.
3. req=4'b0100 alone held for 20 cycles -> gnt=0100 continuously, no preemption. At cycle 12 raise req[1] -> gnt drops one cycle after hold_cnt saturates and contention is seen, GAP, then gnt=0010.
4. Owner 2 releases while req[0] and req[3] are pending -> GAP, then gnt=1000 (id 3 before 0 when searching from owner+1).
5. rst=1 asserted mid-GRANT with gnt=0010 -> next edge: gnt=0, busy=0, state_num=0; after release with req=4'b0011 -> gnt=0001.
6. MAX_HOLD=1 with req=4'b0011 -> alternating pattern: gnt 0001, GAP, 0010, GAP, repeating; no two consecutive cycles with the same nonzero gnt.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin Moore arbiter: state codes,
// requester count, picker result type and a one-hot decode helper.
package arb_pkg;

  localparam int N_REQ = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_GRANT = S_GRANT,
    ST_GAP   = S_GAP
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  // Decode a requester index into a one-hot request/grant vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] i);
    logic [N_REQ-1:0] o;
    o    = '0;
    o[i] = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: searches from base+1 upward
// with wrap, so base itself is checked last.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       base,
  output logic             valid,
  output logic [1:0]       idx
);

  logic [1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    idx   = base;
    cand  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = base + 2'(i);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_moore_arbiter.sv
// Four-requester round-robin arbiter, Moore style. Grants are bounded by
// MAX_HOLD cycles when others are waiting, and every hand-over passes
// through a one-cycle GAP with no grant. Outputs are registered from the
// next-state/next-owner values, so nothing reaches them from req directly.
module rr_moore_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic [1:0]       state_num
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [1:0]       state_num_q, state_num_d;

  logic [1:0] pick_base;
  pick_t      pick;

  // GAP rotates from the owner just released; IDLE from the last owner.
  assign pick_base = (state_q == ST_GAP) ? owner_q : last_q;

  rr_pick u_pick (
    .req   (req),
    .base  (pick_base),
    .valid (pick.valid),
    .idx   (pick.idx)
  );

  // Next-state, tenure counting and output decode from the next state.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick.valid) begin
          state_d    = ST_GRANT;
          owner_d    = pick.idx;
          hold_cnt_d = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (!req[owner_q]) begin
          state_d = ST_GAP;
        end else if (hold_cnt_q == HOLD_MAX &&
                     (req & ~onehot(owner_q)) != '0) begin
          state_d = ST_GAP;
        end else if (hold_cnt_q != HOLD_MAX) begin
          // Saturates so a lone requester keeps the grant indefinitely.
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        last_d = owner_q;
        if (pick.valid) begin
          state_d    = ST_GRANT;
          owner_d    = pick.idx;
          hold_cnt_d = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    gnt_d       = (state_d == ST_GRANT) ? onehot(owner_d) : '0;
    busy_d      = (state_d == ST_GRANT);
    state_num_d = state_d;
  end

  // State, owner, rotation pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 2'd0;
      last_q      <= 2'd3;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      state_num_q <= S_IDLE;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      state_num_q <= state_num_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = owner_q;
  assign busy      = busy_q;
  assign state_num = state_num_q;

endmodule
